// File: rtl/de4_sopc_switch_poller.sv
// Avalon-MM read master that polls the switch PIO data register at a fixed interval,
// debounces the 16-bit sample and publishes a stable word plus one-clock change strobes.
module de4_sopc_switch_poller #(
  parameter int POLL_INTERVAL  = 50000,
  parameter int DEBOUNCE_COUNT = 4,
  parameter int READ_LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [15:0] switches,
  output logic        switches_valid,
  output logic        change_pulse,
  output logic [15:0] changed_bits
);

  localparam int IW = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [IW-1:0] IV_LAST  = IW'(POLL_INTERVAL - 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(READ_LATENCY - 1);
  localparam logic [3:0]    DB_MAX   = 4'(DEBOUNCE_COUNT);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_REQ  = 2'd1,
    ST_LAT  = 2'd2
  } state_t;

  state_t        state_q;
  logic [IW-1:0] interval_q;
  logic [LW-1:0] lat_q;
  logic [15:0]   cand_q, cand_d;
  logic [3:0]    stable_q, stable_d;
  logic [15:0]   sw_q;
  logic          valid_q;
  logic          pulse_q;
  logic [15:0]   changed_q;
  logic          read_q;
  logic [15:0]   sample;
  logic          accept;

  // Upper half of the PIO data word carries nothing we use.
  logic unused_hi;
  assign unused_hi = ^avm_readdata[31:16];

  assign sample = avm_readdata[15:0];

  // Debounce evaluation of the word presented at the capture edge.
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    if (sample == cand_q) begin
      if (stable_q < DB_MAX) stable_d = stable_q + 4'd1;
    end else begin
      cand_d   = sample;
      stable_d = 4'd1;
    end
    accept = (stable_d == DB_MAX) && (!valid_q || (cand_d != sw_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_WAIT;
      interval_q <= '0;
      lat_q      <= '0;
      cand_q     <= '0;
      stable_q   <= '0;
      sw_q       <= '0;
      valid_q    <= 1'b0;
      pulse_q    <= 1'b0;
      changed_q  <= '0;
      read_q     <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      unique case (state_q)
        ST_WAIT: begin
          if (enable) begin
            if (interval_q == IV_LAST) begin
              interval_q <= '0;
              read_q     <= 1'b1;
              state_q    <= ST_REQ;
            end else begin
              interval_q <= interval_q + 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (!avm_waitrequest) begin
            read_q  <= 1'b0;
            lat_q   <= LAT_INIT;
            state_q <= ST_LAT;
          end
        end
        ST_LAT: begin
          if (lat_q == '0) begin
            state_q  <= ST_WAIT;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            if (accept) begin
              sw_q    <= cand_d;
              valid_q <= 1'b1;
              // The very first accepted word is not a change.
              if (valid_q) begin
                changed_q <= sw_q ^ cand_d;
                pulse_q   <= 1'b1;
              end
            end
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        default: state_q <= ST_WAIT;
      endcase
    end
  end

  assign avm_address    = 2'b00;
  assign avm_read       = read_q;
  assign switches       = sw_q;
  assign switches_valid = valid_q;
  assign change_pulse   = pulse_q;
  assign changed_bits   = changed_q;

endmodule

// File: tb/tb_de4_sopc_switch_poller.sv
// Bench for de4_sopc_switch_poller: PIO slave model, debounce reference model feeding a
// scoreboard of expected output words, and scenario tasks run in sequence.
module tb_de4_sopc_switch_poller;
  localparam int PI = 4;
  localparam int DC = 3;
  localparam int RL = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [15:0] switches, changed_bits;
  logic        switches_valid, change_pulse;
  logic [15:0] in_port = '0;

  int checks = 0;
  int fails  = 0;
  int rd     = 0;

  // monitor-owned state
  int          negcnt = 0, pulse_hi = 0, exp_pulses = 0, addr_bad = 0;
  int          rise_cnt = 0, acc_cnt = 0, pairs_total = 0;
  int          rise_q[$];
  int          due_q[$];
  logic [33:0] exp_q[$];
  logic [33:0] pexp_q[$];
  logic [33:0] pobs_q[$];
  logic        prev_read = 1'b0;
  logic [15:0] m_cand = '0, m_sw = '0, m_chg = '0;
  int          m_cnt = 0;
  logic        m_valid = 1'b0, m_pulse = 1'b0;

  de4_sopc_switch_poller #(
    .POLL_INTERVAL(PI), .DEBOUNCE_COUNT(DC), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .switches(switches), .switches_valid(switches_valid),
    .change_pulse(change_pulse), .changed_bits(changed_bits)
  );

  always #5 clk = ~clk;

  // PIO slave: one-clock read latency, junk in the unused upper half.
  always @(posedge clk)
    if (avm_read && !avm_waitrequest) avm_readdata <= {16'($urandom), in_port};

  always @(negedge clk) begin
    negcnt++;
    if (reset) begin
      exp_q.delete();
      due_q.delete();
      m_cand = '0; m_sw = '0; m_chg = '0; m_cnt = 0; m_valid = 1'b0;
    end else begin
      if (change_pulse) pulse_hi++;
      if (avm_read && !prev_read) begin rise_cnt++; rise_q.push_back(negcnt); end
      if (avm_read && avm_address != 2'b00) addr_bad++;
      if (due_q.size() > 0 && due_q[0] == negcnt) begin
        void'(due_q.pop_front());
        pexp_q.push_back(exp_q.pop_front());
        pobs_q.push_back({switches_valid, change_pulse, changed_bits, switches});
        pairs_total++;
      end
      if (avm_read && !avm_waitrequest) begin
        acc_cnt++;
        m_pulse = 1'b0;
        if (in_port == m_cand) begin
          if (m_cnt < DC) m_cnt++;
        end else begin
          m_cand = in_port;
          m_cnt  = 1;
        end
        if (m_cnt == DC && (!m_valid || m_cand != m_sw)) begin
          if (m_valid) begin m_chg = m_sw ^ m_cand; m_pulse = 1'b1; exp_pulses++; end
          m_sw = m_cand;
          m_valid = 1'b1;
        end
        exp_q.push_back({m_valid, m_pulse, m_chg, m_sw});
        due_q.push_back(negcnt + RL + 1);
      end
    end
    prev_read = avm_read;
  end

  task automatic wait_caps(input int n, output bit ok);
    int target;
    target = pairs_total + n;
    ok = 1'b0;
    for (int c = 0; c < 40 * n; c++) begin
      @(negedge clk); #1;
      if (pairs_total >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_read(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); #1;
      if (avm_read) begin ok = 1'b1; break; end
    end
  endtask

  int rel_neg;

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({avm_read, avm_address} !== 3'b000) begin
      fails++; $display("FAIL reset_bus: got read=%b addr=%0d want 0/0", avm_read, avm_address);
    end
    checks++;
    if ({switches_valid, switches} !== 17'h0) begin
      fails++; $display("FAIL reset_sw: got valid=%b sw=%h want 0/0000", switches_valid, switches);
    end
    checks++;
    if ({change_pulse, changed_bits} !== 17'h0) begin
      fails++; $display("FAIL reset_chg: got pulse=%b chg=%h want 0/0000", change_pulse, changed_bits);
    end
    @(posedge clk); #1;
    reset   = 1'b0;
    in_port = 16'h00A5;
    rel_neg = negcnt;
  endtask

  task automatic test_steady();
    bit ok;
    int r0;
    r0 = rise_q.size();
    wait_caps(3, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL steady_timeout: got %0d captures want 3", pairs_total); end
    checks++;
    if (rise_q.size() < r0 + 3) begin
      fails++; $display("FAIL steady_reads: got %0d reads want 3", rise_q.size() - r0);
    end else begin
      if (rise_q[r0] !== rel_neg + 5) begin
        fails++; $display("FAIL first_read: got negedge %0d want %0d", rise_q[r0], rel_neg + 5);
      end
      checks++;
      if (rise_q[r0+1] - rise_q[r0] !== 6 || rise_q[r0+2] - rise_q[r0+1] !== 6) begin
        fails++; $display("FAIL poll_period: got %0d,%0d want 6,6",
                          rise_q[r0+1] - rise_q[r0], rise_q[r0+2] - rise_q[r0+1]);
      end
    end
    checks++;
    if ({switches_valid, switches} !== {1'b1, 16'h00A5}) begin
      fails++; $display("FAIL steady_sw: got valid=%b sw=%h want 1/00a5", switches_valid, switches);
    end
    checks++;
    if (pulse_hi !== 0) begin fails++; $display("FAIL steady_pulse: got %0d pulses want 0", pulse_hi); end
    while (rd < pairs_total) begin
      checks++;
      if (pobs_q[rd] !== pexp_q[rd]) begin
        fails++; $display("FAIL sb_steady cap %0d: got %h want %h", rd, pobs_q[rd], pexp_q[rd]);
      end
      rd++;
    end
  endtask

  task automatic test_change();
    bit ok;
    @(posedge clk); #1;
    in_port = 16'h00A4;
    wait_caps(3, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL change_timeout: got %0d captures", pairs_total); end
    checks++;
    if ({switches, changed_bits} !== {16'h00A4, 16'h0001}) begin
      fails++; $display("FAIL change_val: got sw=%h chg=%h want 00a4/0001", switches, changed_bits);
    end
    checks++;
    if (pulse_hi !== 1) begin fails++; $display("FAIL change_pulse: got %0d pulse clocks want 1", pulse_hi); end
    while (rd < pairs_total) begin
      checks++;
      if (pobs_q[rd] !== pexp_q[rd]) begin
        fails++; $display("FAIL sb_change cap %0d: got %h want %h", rd, pobs_q[rd], pexp_q[rd]);
      end
      rd++;
    end
  endtask

  task automatic test_bounce();
    bit ok;
    @(posedge clk); #1;
    in_port = 16'h00A5;
    wait_caps(3, ok);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_port = (i % 2 == 0) ? 16'h00A4 : 16'h00A5;
      wait_caps(1, ok);
    end
    checks++;
    if (switches !== 16'h00A5 || pulse_hi !== 2) begin
      fails++; $display("FAIL bounce_hold: got sw=%h pulses=%0d want 00a5/2", switches, pulse_hi);
    end
    @(posedge clk); #1;
    in_port = 16'h00A4;
    wait_caps(2, ok);
    checks++;
    if (switches !== 16'h00A5) begin
      fails++; $display("FAIL bounce_early: got sw=%h after 2 samples want 00a5", switches);
    end
    wait_caps(1, ok);
    checks++;
    if (!ok || switches !== 16'h00A4 || pulse_hi !== 3) begin
      fails++; $display("FAIL bounce_settle: got sw=%h pulses=%0d want 00a4/3", switches, pulse_hi);
    end
    while (rd < pairs_total) begin
      checks++;
      if (pobs_q[rd] !== pexp_q[rd]) begin
        fails++; $display("FAIL sb_bounce cap %0d: got %h want %h", rd, pobs_q[rd], pexp_q[rd]);
      end
      rd++;
    end
  endtask

  task automatic test_enable();
    bit ok;
    int n0, rc, pt;
    wait_read(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL en_timeout: got no read want read"); end
    n0 = negcnt;
    repeat (4) @(posedge clk); #1;
    enable = 1'b0;
    repeat (10) @(posedge clk); #1;
    enable = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (avm_read !== 1'b0 || rise_q[rise_q.size()-1] !== n0) begin
      fails++; $display("FAIL en_frozen: got read=%b at clk %0d want 0", avm_read, negcnt - n0);
    end
    @(negedge clk); #1;
    checks++;
    if (avm_read !== 1'b1 || negcnt - n0 !== 16) begin
      fails++; $display("FAIL en_resume: got read=%b at clk %0d want 1 at 16", avm_read, negcnt - n0);
    end
    enable = 1'b0;
    pt = pairs_total;
    rc = rise_cnt;
    repeat (2) begin @(negedge clk); #1; end
    checks++;
    if (pairs_total !== pt + 1 || avm_read !== 1'b0) begin
      fails++; $display("FAIL en_inflight: got %0d captures read=%b want %0d/0", pairs_total - pt, avm_read, 1);
    end
    repeat (10) begin @(negedge clk); #1; end
    checks++;
    if (rise_cnt !== rc) begin fails++; $display("FAIL en_idle: got %0d reads want 0", rise_cnt - rc); end
    @(posedge clk); #1;
    enable = 1'b1;
    while (rd < pairs_total) begin
      checks++;
      if (pobs_q[rd] !== pexp_q[rd]) begin
        fails++; $display("FAIL sb_enable cap %0d: got %h want %h", rd, pobs_q[rd], pexp_q[rd]);
      end
      rd++;
    end
  endtask

  task automatic test_waitreq();
    bit ok;
    int ac, pt;
    avm_waitrequest = 1'b1;
    ac = acc_cnt;
    pt = pairs_total;
    wait_read(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL wr_timeout: got no read want read"); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (avm_read !== 1'b1 || avm_address !== 2'b00) begin
        fails++; $display("FAIL wr_hold clk %0d: got read=%b addr=%0d want 1/0", i, avm_read, avm_address);
      end
      @(posedge clk); #1;
      if (i == 4) avm_waitrequest = 1'b0;
      @(negedge clk); #1;
    end
    checks++;
    if (avm_read !== 1'b0 || acc_cnt !== ac + 1 || pairs_total !== pt) begin
      fails++; $display("FAIL wr_accept: got read=%b accepts=%0d caps=%0d want 0/1/0",
                        avm_read, acc_cnt - ac, pairs_total - pt);
    end
    @(negedge clk); #1;
    checks++;
    if (pairs_total !== pt + 1) begin
      fails++; $display("FAIL wr_capture: got %0d captures want 1", pairs_total - pt);
    end
    while (rd < pairs_total) begin
      checks++;
      if (pobs_q[rd] !== pexp_q[rd]) begin
        fails++; $display("FAIL sb_waitreq cap %0d: got %h want %h", rd, pobs_q[rd], pexp_q[rd]);
      end
      rd++;
    end
  endtask

  task automatic test_reset_lat();
    bit ok;
    wait_read(ok);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({avm_read, avm_address, switches_valid, switches, change_pulse, changed_bits} !== 36'h0) begin
      fails++; $display("FAIL rst_lat_vals: got read=%b valid=%b sw=%h pulse=%b chg=%h want all 0",
                        avm_read, switches_valid, switches, change_pulse, changed_bits);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++;
      if (avm_read !== 1'b0) begin fails++; $display("FAIL rst_lat_early clk %0d: got read=1 want 0", k + 1); end
    end
    @(negedge clk); #1;
    checks++;
    if (avm_read !== 1'b1) begin fails++; $display("FAIL rst_lat_first: got read=%b at clk 4 want 1", avm_read); end
    wait_caps(3, ok);
    checks++;
    if (!ok || {switches_valid, switches} !== {1'b1, in_port} || pulse_hi !== 3) begin
      fails++; $display("FAIL rst_lat_reacq: got valid=%b sw=%h pulses=%0d want 1/%h/3",
                        switches_valid, switches, pulse_hi, in_port);
    end
    checks++;
    if (addr_bad !== 0 || pulse_hi !== exp_pulses) begin
      fails++; $display("FAIL totals: got addr_bad=%0d pulses=%0d want 0/%0d", addr_bad, pulse_hi, exp_pulses);
    end
    while (rd < pairs_total) begin
      checks++;
      if (pobs_q[rd] !== pexp_q[rd]) begin
        fails++; $display("FAIL sb_reset cap %0d: got %h want %h", rd, pobs_q[rd], pexp_q[rd]);
      end
      rd++;
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_change();
    test_bounce();
    test_enable();
    test_waitreq();
    test_reset_lat();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/de4_sopc_switch_poller.md
# de4_sopc_switch_poller

Avalon-MM master that periodically reads the data register of the board switch input PIO, debounces the 16-bit value, and presents a stable switch word plus change events to fabric logic. It is the initiator for that PIO slave: it issues single-word reads at a fixed interval, waits out the slave's fixed read latency, and requires several consecutive identical samples before accepting a new value. It sits beside the SOPC interconnect on the system clock domain.

## Interface
- POLL_INTERVAL, 50000: clocks between read issues; legal range 2..2^20.
- DEBOUNCE_COUNT, 4: consecutive identical samples needed to accept a value; legal range 1..15.
- READ_LATENCY, 1: slave fixed read latency in clocks; legal range 1..4.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  polling enable; gates only the interval counter.
- avm_address  out  2  always 0 (PIO data register).
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data; bits [15:0] are used, [31:16] are ignored.
- switches  out  16  debounced switch value.
- switches_valid  out  1  high once the first value has been accepted.
- change_pulse  out  1  one-clock strobe on an accepted change.
- changed_bits  out  16  old XOR new value; held until the next change.

## Operation
- States: WAIT, REQ, LAT. Reset state is WAIT.
- WAIT:
  - interval_cnt increments each clock while enable=1 and holds while enable=0.
  - When interval_cnt == POLL_INTERVAL-1 and enable=1: clear interval_cnt and go to REQ.
- REQ:
  - avm_read=1 and avm_address=0.
  - Hold while avm_waitrequest=1.
  - The read is accepted at the edge where avm_read=1 and avm_waitrequest=0. At that edge go to LAT and load lat_cnt=READ_LATENCY-1.
- LAT:
  - avm_read=0.
  - Decrement lat_cnt each clock.
  - At the edge where lat_cnt==0, capture sample=avm_readdata[15:0], evaluate it, and return to WAIT. interval_cnt restarts from 0.
- Evaluation at the capture edge:
  - If sample == candidate: stable_cnt = min(stable_cnt+1, DEBOUNCE_COUNT). Otherwise candidate=sample and stable_cnt=1.
  - Acceptance condition: the new stable_cnt == DEBOUNCE_COUNT and (switches_valid==0 or candidate != switches).
  - On acceptance:
    - switches = candidate (new value).
    - switches_valid = 1.
    - If switches_valid was already 1: changed_bits = old switches XOR new, and change_pulse=1 for one clock.
    - The first acceptance after reset produces no pulse and leaves changed_bits at 0.
- enable=0 does not abort an in-flight read. REQ and LAT complete, then the block waits in WAIT.
- The block never issues a write. Only one read is outstanding at a time.

## Timing
- Reset values: avm_read=0, avm_address=0, switches=0, switches_valid=0, change_pulse=0, changed_bits=0. Internally interval_cnt=0, stable_cnt=0, candidate=0, state=WAIT.
- A reset asserted in REQ or LAT abandons the read. avm_read is 0 from the reset edge, and any late readdata is ignored. This is safe because PIO reads have no side effects.
- All outputs are registered. avm_read rises on the edge that enters REQ.
- Poll period with waitrequest=0 and enable=1: POLL_INTERVAL + 1 + READ_LATENCY clocks between successive read issues.
- Sample-to-output latency: switches, changed_bits and change_pulse update on the capture edge itself, i.e. READ_LATENCY clocks after the acceptance edge.
- Worst-case change detection: DEBOUNCE_COUNT poll periods after the input settles, plus up to one extra period if the input changes mid-poll.
- With DEBOUNCE_COUNT=1, every differing sample is accepted immediately.

## Test plan
Parameters for all scenarios: POLL_INTERVAL=4, DEBOUNCE_COUNT=3, READ_LATENCY=1; slave model returns in_port with 1-clock latency.
- Reset then steady in_port=0x00A5, enable=1, waitrequest=0 -> read every 6 clocks; switches=0x00A5 and switches_valid=1 on the 3rd capture edge; change_pulse never asserted.
- After that, in_port=0x00A4 held -> on the 3rd subsequent capture, switches=0x00A4, changed_bits=0x0001, change_pulse high exactly 1 clock.
- Bounce 0x00A5/0x00A4 alternating every poll -> switches stays 0x00A5, no pulse; then 0x00A4 held -> accepted after 3 samples.
- waitrequest held high for 5 clocks in REQ -> avm_read stays 1 and address stays 0 for all 6 clocks; the capture occurs 1 clock after release; no duplicate read.
- enable dropped in WAIT for 10 clocks -> no avm_read and interval_cnt frozen; resume -> read issues after the remaining count. enable dropped during REQ -> that read still completes.
- reset pulsed 1 clock during LAT -> next clock all outputs at reset values and state WAIT; the first new read issues at clock 4 after reset release.
